// File: rtl/banner_text_ctrl.sv
// banner_text_ctrl: walks the banner character slots of each scanline and emits glyph codes
// with slot-local coordinates; message changes apply at frame start. Blinking: BANNER_BLINK_EN.
module banner_text_ctrl #(
    parameter int X_ORIGIN     = 128,
    parameter int Y_ORIGIN     = 128,
    parameter int MAX_CHARS    = 9,
    parameter int V_ACTIVE     = 768,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [1:0]  msg_sel_in,
    input  logic        msg_valid_in,
    output logic        msg_ready_out,
    input  logic [11:0] color_in,
    input  logic [3:0]  scale_in,
    input  logic        blink_en_in,
    output logic [4:0]  letter_out,
    output logic [10:0] glyph_hcount_out,
    output logic [9:0]  glyph_vcount_out,
    output logic [11:0] color_out,
    output logic [3:0]  scale_out,
    output logic        active_out
);
    localparam int SLOT_W = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
    localparam logic [10:0]       X_START   = 11'(X_ORIGIN);
    localparam logic [10:0]       Y_START   = 11'(Y_ORIGIN);
    localparam logic [10:0]       V_END     = 11'(V_ACTIVE);
    localparam logic [9:0]        Y_OFFSET  = 10'(Y_ORIGIN);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(MAX_CHARS - 1);

    localparam logic [4:0] L_BLANK = 5'd0;
    localparam logic [4:0] L_G     = 5'd1;
    localparam logic [4:0] L_A     = 5'd2;
    localparam logic [4:0] L_M     = 5'd3;
    localparam logic [4:0] L_E     = 5'd4;
    localparam logic [4:0] L_O     = 5'd5;
    localparam logic [4:0] L_V     = 5'd6;
    localparam logic [4:0] L_R     = 5'd7;
    localparam logic [4:0] L_H     = 5'd8;
    localparam logic [4:0] L_P     = 5'd9;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    function automatic logic [4:0] rom_letter(input logic [1:0] msg, input logic [SLOT_W-1:0] slot);
        logic [4:0] code;
        code = L_BLANK;
        case (msg)
            2'd1: begin
                case (int'(slot))
                    0:       code = L_G;
                    1:       code = L_A;
                    2:       code = L_M;
                    3:       code = L_E;
                    5:       code = L_O;
                    6:       code = L_V;
                    7:       code = L_E;
                    8:       code = L_R;
                    default: code = L_BLANK;
                endcase
            end
            2'd2: begin
                case (int'(slot))
                    0:       code = L_H;
                    1:       code = L_O;
                    2:       code = L_M;
                    3:       code = L_E;
                    default: code = L_BLANK;
                endcase
            end
            2'd3: begin
                case (int'(slot))
                    0:       code = L_M;
                    1:       code = L_A;
                    2:       code = L_P;
                    default: code = L_BLANK;
                endcase
            end
            default: code = L_BLANK;
        endcase
        return code;
    endfunction

    state_t            state_q, state_d;
    logic [7:0]        col_q, col_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [7:0]        pitch_q, pitch_d;
    logic [1:0]        cur_msg_q, pend_msg_q;
    logic              pending_q;

    logic [1:0]        scl;
    logic [10:0]       v_ext;
    logic [10:0]       band_end;
    logic              in_band;
    logic [7:0]        pitch_new;
    logic              frame_start;
    logic              xfer;
    logic              visible;

    logic              pix_on;
    logic [7:0]        pix_col;
    logic [SLOT_W-1:0] pix_slot;
    logic [4:0]        pix_letter;
    logic              show;

    assign scl         = scale_in[1:0];
    assign v_ext       = {1'b0, vcount_in};
    assign band_end    = Y_START + (11'd12 << scl);
    assign in_band     = (v_ext >= Y_START) && (v_ext < band_end) && (v_ext < V_END);
    assign pitch_new   = 8'd20 << scl;
    assign frame_start = (hcount_in == '0) && (vcount_in == '0);
    assign xfer        = msg_valid_in && !pending_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            col_q   <= '0;
            slot_q  <= '0;
            pitch_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            slot_q  <= slot_d;
            pitch_q <= pitch_d;
        end
    end

    // The IDLE->SCAN cycle renders column 0 of slot 0 itself, so the counter resumes at 1.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        slot_d   = slot_q;
        pitch_d  = pitch_q;
        pix_on   = 1'b0;
        pix_col  = '0;
        pix_slot = '0;
        case (state_q)
            IDLE: begin
                col_d  = '0;
                slot_d = '0;
                if (in_band && hcount_in == X_START) begin
                    state_d = SCAN;
                    pitch_d = pitch_new;
                    col_d   = 8'd1;
                    pix_on  = 1'b1;
                end
            end
            SCAN: begin
                pix_on   = 1'b1;
                pix_col  = col_q;
                pix_slot = slot_q;
                if (col_q == pitch_q - 8'd1) begin
                    col_d = '0;
                    if (slot_q == LAST_SLOT) begin
                        state_d = DONE;
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 8'd1;
                end
            end
            DONE: begin
                if (hcount_in == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!in_band) begin
            state_d = IDLE;
            pix_on  = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cur_msg_q  <= '0;
            pend_msg_q <= '0;
            pending_q  <= 1'b0;
        end else begin
            if (frame_start) begin
                cur_msg_q <= pend_msg_q;
                pending_q <= xfer;
            end else if (xfer) begin
                pending_q <= 1'b1;
            end
            if (xfer) begin
                pend_msg_q <= msg_sel_in;
            end
        end
    end

    assign msg_ready_out = !pending_q;

`ifdef BANNER_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] frame_cnt_q;
    logic            hidden_q;

    always_ff @(posedge clk_in) begin
        if (rst_in || !blink_en_in) begin
            frame_cnt_q <= '0;
            hidden_q    <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_q <= '0;
                hidden_q    <= !hidden_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign visible = !hidden_q;
`else
    logic unused_blink;
    assign unused_blink = blink_en_in ^ (BLINK_FRAMES == 0);
    assign visible      = 1'b1;
`endif

    assign pix_letter = rom_letter(cur_msg_q, pix_slot);
    assign show       = pix_on && visible && (pix_letter != L_BLANK);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            letter_out       <= '0;
            glyph_hcount_out <= '0;
            glyph_vcount_out <= '0;
            color_out        <= '0;
            scale_out        <= '0;
            active_out       <= 1'b0;
        end else begin
            letter_out       <= show ? pix_letter : L_BLANK;
            glyph_hcount_out <= show ? {3'b000, pix_col} : '0;
            glyph_vcount_out <= vcount_in - Y_OFFSET;
            color_out        <= show ? color_in : '0;
            scale_out        <= scale_in;
            active_out       <= show;
        end
    end

endmodule
